// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: collapsing age-ordered array with CDB wakeup and branch flush.
// Latency: dispatch to earliest issue is 1 cycle; CDB wakeup becomes visible as ready the next cycle.
// Backpressure: issue waits for issue_ready; disp_en is dropped while queue_full (optional RS_CDB_BYPASS_EN).
module rs_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 7,
  parameter int OP_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_en,
  input  logic [OP_W-1:0]            disp_opcode,
  input  logic [TAG_W-1:0]           disp_rd_tag,
  input  logic                       disp_rs_valid,
  input  logic [TAG_W-1:0]           disp_rs_tag,
  input  logic [DATA_W-1:0]          disp_rs_data,
  input  logic                       disp_rt_valid,
  input  logic [TAG_W-1:0]           disp_rt_tag,
  input  logic [DATA_W-1:0]          disp_rt_data,
  output logic                       queue_full,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  input  logic                       cdb_branch,
  input  logic                       cdb_branch_taken,
  input  logic                       issue_ready,
  output logic                       issue_valid,
  output logic [OP_W-1:0]            issue_opcode,
  output logic [TAG_W-1:0]           issue_rd_tag,
  output logic [DATA_W-1:0]          issue_rs_data,
  output logic [DATA_W-1:0]          issue_rt_data
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rd_tag;
    logic              rs_v;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rs_d;
    logic              rt_v;
    logic [TAG_W-1:0]  rt_tag;
    logic [DATA_W-1:0] rt_d;
  } entry_t;

  entry_t           q   [DEPTH];  // registered entries, index 0 = oldest
  entry_t           w_q [DEPTH];  // entries after this cycle's CDB wakeup
  entry_t           n_q [DEPTH];  // next-state entries
  entry_t           d_ent;        // entry being dispatched this cycle
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] n_count;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  int               sel_pos;
  int               wr_pos;
  logic             flush;
  logic             do_issue;
  logic             do_disp;

  assign queue_count = count_q;
  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign flush       = cdb_valid & cdb_branch & cdb_branch_taken;
  // A flush discards both handshakes of the same cycle.
  assign do_issue    = sel_found & issue_ready & ~flush;
  assign do_disp     = disp_en & ~queue_full & ~flush;

  // Age-ordered select: lowest-index entry with both operands present.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_pos   = 0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (q[i].valid && q[i].rs_v && q[i].rt_v) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_pos   = i;
      end
    end
  end

  // Issue outputs come straight from registered state; zero when nothing is ready.
  always_comb begin
    issue_valid   = sel_found;
    issue_opcode  = '0;
    issue_rd_tag  = '0;
    issue_rs_data = '0;
    issue_rt_data = '0;
    if (sel_found) begin
      issue_opcode  = q[sel_idx].op;
      issue_rd_tag  = q[sel_idx].rd_tag;
      issue_rs_data = q[sel_idx].rs_d;
      issue_rt_data = q[sel_idx].rt_d;
    end
  end

  // Build the incoming entry; with the bypass, a same-cycle CDB result fills a waiting operand.
  always_comb begin
    d_ent        = '0;
    d_ent.valid  = 1'b1;
    d_ent.op     = disp_opcode;
    d_ent.rd_tag = disp_rd_tag;
    d_ent.rs_v   = disp_rs_valid;
    d_ent.rs_tag = disp_rs_tag;
    d_ent.rs_d   = disp_rs_data;
    d_ent.rt_v   = disp_rt_valid;
    d_ent.rt_tag = disp_rt_tag;
    d_ent.rt_d   = disp_rt_data;
`ifdef RS_CDB_BYPASS_EN
    if (cdb_valid && !disp_rs_valid && disp_rs_tag == cdb_tag) begin
      d_ent.rs_v = 1'b1;
      d_ent.rs_d = cdb_data;
    end
    if (cdb_valid && !disp_rt_valid && disp_rt_tag == cdb_tag) begin
      d_ent.rt_v = 1'b1;
      d_ent.rt_d = cdb_data;
    end
`endif
  end

  // CDB wakeup: waiting operands whose producer tag matches capture the broadcast data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_q[i] = q[i];
      if (cdb_valid && q[i].valid && !q[i].rs_v && q[i].rs_tag == cdb_tag) begin
        w_q[i].rs_v = 1'b1;
        w_q[i].rs_d = cdb_data;
      end
      if (cdb_valid && q[i].valid && !q[i].rt_v && q[i].rt_tag == cdb_tag) begin
        w_q[i].rt_v = 1'b1;
        w_q[i].rt_d = cdb_data;
      end
    end
  end

  // Next state: collapse over the issued slot, append the dispatch behind the survivors, flush clears all.
  always_comb begin
    wr_pos = int'(count_q) - (do_issue ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      n_q[i] = w_q[i];
    end
    if (do_issue) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        if (i >= sel_pos) begin
          n_q[i] = w_q[i+1];
        end
      end
      n_q[DEPTH-1] = '0;
    end
    if (do_disp) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == wr_pos) begin
          n_q[i] = d_ent;
        end
      end
    end
    n_count = count_q + CNT_W'(do_disp) - CNT_W'(do_issue);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        n_q[i] = '0;
      end
      n_count = '0;
    end
  end

  // State register; synchronous reset overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      q       <= n_q;
      count_q <= n_count;
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue (DEPTH=4): reset, issue, wakeup ordering, full, flush, bypass.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Expected values are hand-derived constants.
module tb_rs_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_en;
  logic [3:0]  disp_opcode;
  logic [6:0]  disp_rd_tag;
  logic        disp_rs_valid;
  logic [6:0]  disp_rs_tag;
  logic [31:0] disp_rs_data;
  logic        disp_rt_valid;
  logic [6:0]  disp_rt_tag;
  logic [31:0] disp_rt_data;
  logic        queue_full;
  logic [2:0]  queue_count;
  logic        cdb_valid;
  logic [6:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_branch;
  logic        cdb_branch_taken;
  logic        issue_ready;
  logic        issue_valid;
  logic [3:0]  issue_opcode;
  logic [6:0]  issue_rd_tag;
  logic [31:0] issue_rs_data;
  logic [31:0] issue_rt_data;

  int n_tests = 0;
  int n_fail  = 0;

  rs_issue_queue #(.DEPTH(4), .DATA_W(32), .TAG_W(7), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .disp_en(disp_en), .disp_opcode(disp_opcode), .disp_rd_tag(disp_rd_tag),
    .disp_rs_valid(disp_rs_valid), .disp_rs_tag(disp_rs_tag), .disp_rs_data(disp_rs_data),
    .disp_rt_valid(disp_rt_valid), .disp_rt_tag(disp_rt_tag), .disp_rt_data(disp_rt_data),
    .queue_full(queue_full), .queue_count(queue_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_rd_tag(issue_rd_tag), .issue_rs_data(issue_rs_data), .issue_rt_data(issue_rt_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op on the dispatch port (disp_en is set by the caller).
  task automatic set_disp(input logic [3:0] op, input logic [6:0] rd,
                          input logic rsv, input logic [6:0] rst_tag, input logic [31:0] rsd,
                          input logic rtv, input logic [6:0] rtt, input logic [31:0] rtd);
    disp_opcode   = op;
    disp_rd_tag   = rd;
    disp_rs_valid = rsv;
    disp_rs_tag   = rst_tag;
    disp_rs_data  = rsd;
    disp_rt_valid = rtv;
    disp_rt_tag   = rtt;
    disp_rt_data  = rtd;
  endtask

  initial begin
    rst = 1'b1; disp_en = 1'b1;
    set_disp(4'h1, 7'd1, 1'b1, 7'd0, 32'h1, 1'b1, 7'd0, 32'h2);
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
    issue_ready = 1'b0;

    // 1: reset held two cycles with dispatch asserted
    step(); step();
    rst = 1'b0; disp_en = 1'b0;
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_full",  64'(queue_full),  64'd0);
    chk("rst_ivld",  64'(issue_valid), 64'd0);
    chk("rst_iop",   64'(issue_opcode), 64'd0);
    chk("rst_irs",   64'(issue_rs_data), 64'd0);

    // 2: single ready op, issues the cycle after dispatch
    issue_ready = 1'b1; disp_en = 1'b1;
    set_disp(4'h6, 7'd5, 1'b1, 7'd0, 32'd3, 1'b1, 7'd0, 32'd4);
    step();
    disp_en = 1'b0;
    chk("t2_count", 64'(queue_count), 64'd1);
    chk("t2_ivld",  64'(issue_valid), 64'd1);
    chk("t2_op",    64'(issue_opcode), 64'h6);
    chk("t2_rd",    64'(issue_rd_tag), 64'd5);
    chk("t2_rs",    64'(issue_rs_data), 64'd3);
    chk("t2_rt",    64'(issue_rt_data), 64'd4);
    step();
    chk("t2_count_after", 64'(queue_count), 64'd0);
    chk("t2_ivld_after",  64'(issue_valid), 64'd0);

    // 3: older op waits on tag 9, younger ready op issues first
    issue_ready = 1'b0; disp_en = 1'b1;
    set_disp(4'h2, 7'd10, 1'b0, 7'd9, 32'h0, 1'b1, 7'd0, 32'h22);
    step();
    set_disp(4'h3, 7'd11, 1'b1, 7'd0, 32'h1, 1'b1, 7'd0, 32'h2);
    step();
    disp_en = 1'b0;
    chk("t3_count", 64'(queue_count), 64'd2);
    chk("t3_first_rd", 64'(issue_rd_tag), 64'd11);
    issue_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 7'd9; cdb_data = 32'h11;
    step();
    cdb_valid = 1'b0;
    chk("t3_count_mid", 64'(queue_count), 64'd1);
    chk("t3_ivld_a", 64'(issue_valid), 64'd1);
    chk("t3_rd_a",   64'(issue_rd_tag), 64'd10);
    chk("t3_rs_a",   64'(issue_rs_data), 64'h11);
    chk("t3_rt_a",   64'(issue_rt_data), 64'h22);
    step();
    chk("t3_count_end", 64'(queue_count), 64'd0);

    // 4: fill, overflow dispatch dropped, issue+dispatch while full
    issue_ready = 1'b0; disp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_disp(4'h4, 7'(20 + i), 1'b1, 7'd0, 32'(i), 1'b1, 7'd0, 32'h0);
      step();
    end
    chk("t4_full",  64'(queue_full),  64'd1);
    chk("t4_count", 64'(queue_count), 64'd4);
    set_disp(4'h4, 7'd24, 1'b1, 7'd0, 32'h0, 1'b1, 7'd0, 32'h0);
    step();
    chk("t4_count_ovf", 64'(queue_count), 64'd4);
    chk("t4_head_rd",   64'(issue_rd_tag), 64'd20);
    issue_ready = 1'b1;
    set_disp(4'h4, 7'd25, 1'b1, 7'd0, 32'h0, 1'b1, 7'd0, 32'h0);
    step();
    disp_en = 1'b0;
    chk("t4_count_iss", 64'(queue_count), 64'd3);
    chk("t4_full_iss",  64'(queue_full),  64'd0);
    chk("t4_rd21",      64'(issue_rd_tag), 64'd21);
    chk("t4_rs21",      64'(issue_rs_data), 64'd1);
    step();
    chk("t4_rd22", 64'(issue_rd_tag), 64'd22);
    step();
    chk("t4_rd23", 64'(issue_rd_tag), 64'd23);
    step();
    chk("t4_drained", 64'(queue_count), 64'd0);
    chk("t4_no_rd25", 64'(issue_valid), 64'd0);

    // 5: branch not taken leaves queue alone; taken flushes and drops same-cycle dispatch
    issue_ready = 1'b0; disp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_disp(4'h5, 7'(30 + i), 1'b0, 7'(40 + i), 32'h0, 1'b1, 7'd0, 32'h0);
      step();
    end
    disp_en = 1'b0;
    chk("t5_count", 64'(queue_count), 64'd3);
    cdb_valid = 1'b1; cdb_branch = 1'b1; cdb_branch_taken = 1'b0; cdb_tag = 7'd50;
    step();
    chk("t5_nt_count", 64'(queue_count), 64'd3);
    chk("t5_nt_ivld",  64'(issue_valid), 64'd0);
    cdb_branch_taken = 1'b1; disp_en = 1'b1;
    set_disp(4'h5, 7'd33, 1'b1, 7'd0, 32'h0, 1'b1, 7'd0, 32'h0);
    step();
    cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0; disp_en = 1'b0;
    chk("t5_flush_count", 64'(queue_count), 64'd0);
    chk("t5_flush_ivld",  64'(issue_valid), 64'd0);
    // A late wakeup for a flushed tag must not resurrect anything.
    cdb_valid = 1'b1; cdb_tag = 7'd41; cdb_data = 32'h77;
    step();
    cdb_valid = 1'b0;
    chk("t5_post_ivld", 64'(issue_valid), 64'd0);

    // 6: dispatch waiting on tag 7 in the same cycle tag 7 is broadcast
    issue_ready = 1'b0; disp_en = 1'b1;
    set_disp(4'h7, 7'd60, 1'b0, 7'd7, 32'h0, 1'b1, 7'd0, 32'h1);
    cdb_valid = 1'b1; cdb_tag = 7'd7; cdb_data = 32'hAB;
    step();
    disp_en = 1'b0; cdb_valid = 1'b0;
    chk("t6_count", 64'(queue_count), 64'd1);
`ifdef RS_CDB_BYPASS_EN
    chk("t6_ivld", 64'(issue_valid), 64'd1);
    chk("t6_rs",   64'(issue_rs_data), 64'hAB);
`else
    chk("t6_ivld", 64'(issue_valid), 64'd0);
`endif
    // Clear the queue with a taken branch.
    cdb_valid = 1'b1; cdb_branch = 1'b1; cdb_branch_taken = 1'b1;
    step();
    cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
    chk("t6_cleared", 64'(queue_count), 64'd0);

    // 7: tag 0 is a real producer tag; rt wakes, rs already present
    disp_en = 1'b1;
    set_disp(4'h8, 7'd70, 1'b1, 7'd0, 32'h9, 1'b0, 7'd0, 32'h0);
    step();
    disp_en = 1'b0;
    chk("t7_wait", 64'(issue_valid), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 7'd0; cdb_data = 32'h5;
    step();
    cdb_valid = 1'b0;
    chk("t7_ivld", 64'(issue_valid), 64'd1);
    chk("t7_rs",   64'(issue_rs_data), 64'h9);
    chk("t7_rt",   64'(issue_rt_data), 64'h5);
    issue_ready = 1'b1;
    step();
    chk("t7_count_end", 64'(queue_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
